quant_matrix_bank: RTL and testbench
====================================

# quant_matrix_bank

Parametrised MPEG-2 quantiser matrix store. It holds up to four 64-entry matrices: intra luma, non-intra luma, intra chroma and non-intra chroma, each with per-matrix default-value tracking and chroma-follows-luma aliasing per par. 6.3.11. Uploads arrive in scan order and are stored in raster order via `scan_reverse`. It replaces the separate intra and non-intra matrix blocks and feeds the inverse-quantiser datapath.

## Interface
- `dta_width`, default 8: width of `dta_in`/`dta_out`; ≥8; default values zero-extended.
- `matrix_count`, default 4: 2 (4:2:0, luma only) or 4 (4:2:2/4:4:4).
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `rd_addr`  in  6  raster address u*8+v.
- `rd_sel`  in  2  0 intra luma, 1 non-intra luma, 2 intra chroma, 3 non-intra chroma.
- `rd_clk_en`  in  1  read pipeline advance.
- `dta_out`  out  dta_width  quantiser value.
- `wr_addr`  in  6  scan-order index of uploaded value.
- `wr_sel`  in  2  target matrix, encoding as `rd_sel`.
- `dta_in`  in  dta_width  uploaded value.
- `wr_clk_en`  in  1  write-side clock enable.
- `wr_en`  in  1  write request, qualified by `wr_clk_en`.
- `rst_values`  in  1  revert all matrices to defaults, qualified by `wr_clk_en`.
- `alternate_scan`  in  1  selects the scan table for `scan_reverse`.
- `busy`  out  1  high while the RAM clear runs.

## Operation
- **Storage:** one `dpram_sc`. `addr_width` = 6 + log2(`matrix_count`), `dta_width` = `dta_width`. Physical address = {bank, raster addr}.
- **Bank mapping:**
  - `matrix_count`=2: bank = sel[0]; sel[1] is ignored.
  - `matrix_count`=4: bank = sel.
- **Control state machine:** INIT → CLEAR → RUN.
  - INIT lasts 1 cycle.
  - CLEAR writes 0 to every RAM word, one per cycle: 64·`matrix_count` cycles. It exits to RUN after the write of the last address.
  - RUN holds until reset. Any illegal state → INIT.
  - `busy` = 1 in INIT and CLEAR.
  - Upload writes presented while `busy`=1 are dropped. Flag updates still apply.
- **Write path (RUN):** `wr_clk_en && wr_en` registers a RAM write.
  - Address = {bank(`wr_sel`), `scan_reverse(alternate_scan, wr_addr)`}.
  - Data = `dta_in`.
  - The write lands in RAM one cycle after the request.
- **Per-matrix `default_values[m]`:**
  - Reset to 1.
  - Set to 1 on `wr_clk_en && rst_values`.
  - Cleared when the write with `wr_addr`=63 to matrix m is committed to RAM. This is one cycle after the request, so it clears together with the RAM write.
- **Chroma aliasing, `follow[c]` for c ∈ {intra, non-intra}** (only when `matrix_count`=4):
  - Reset to 1; set to 1 by `rst_values`.
  - Set to 1 when the luma upload of the same kind completes (`wr_addr`=63).
  - Cleared when the chroma upload of the same kind completes.
  - While `follow`=1, chroma reads use the luma matrix and the luma default flag.
- **Read value selection:**
  - If the effective default flag = 1: the intra default table (par. 6.3.11, 8…83, raster order) for intra kinds; 16 for non-intra kinds.
  - Otherwise: RAM contents.
- **Simultaneous events:**
  - `rst_values` together with a write: the RAM write happens, and all flags go to defaults.
  - Write with `wr_addr`=63 in the same `wr_clk_en` cycle as `rst_values`: `rst_values` wins.
- **Reset mid-operation:** returns to INIT, flags go to defaults, and CLEAR restarts from address 0.

## Timing
- **Read pipeline:** two stages, both advancing only on `rd_clk_en`.
  - Stage 1 latches the RAM read (RAM read enable = `rd_clk_en`), the default-table value, and the effective default flag.
  - Stage 2 loads `dta_out`.
  - With `rd_clk_en` held high, `dta_out` reflects `rd_addr`/`rd_sel` from 2 clocks earlier.
  - With `rd_clk_en` low, all stages hold.
- **Reset values:**
  - `dta_out` = 0.
  - `busy` = 1 from the first cycle after reset and until RUN is entered.
  - All default and `follow` flags = 1.
- **Read-after-write:** a read of a location issued 2 or more cycles after the write request returns the new value. An earlier read returns the old value.
- **RUN throughput:** one write per clock.

## Test plan
- **Reset and clear:** hold `rst`=0 for 3 cycles, release.
  - `busy` stays high for 1+64·`matrix_count` cycles, then drops.
  - Streaming `rd_sel`=0, addresses 0..63, yields 8,16,19,…,83.
  - `rd_sel`=1 yields 16 everywhere.
- **Intra upload, zigzag:** with `alternate_scan`=0, `wr_sel`=0, write `dta_in`=`wr_addr`+1 for 0..63.
  - Reading raster address 1 returns 2; address 8 returns 3.
  - `rd_sel`=2 returns identical values (follow=1).
- **Chroma override:** after the previous scenario, upload `wr_sel`=2 with all values 50.
  - `rd_sel`=2 returns 50; `rd_sel`=0 remains unchanged.
  - Pulse `rst_values`: all four selects return defaults.
- **Alternate scan and partial upload:** with `alternate_scan`=1, write `wr_addr` 0..62 only to `wr_sel`=1.
  - Reads still return 16.
  - Writing `wr_addr`=63 with value 7: the raster address from `scan_reverse(1,63)` reads 7.
- **Simultaneous events:**
  - `rst_values` together with a `wr_addr`=63 write: defaults persist.
  - Write during `busy`: dropped; after the clear, reads return defaults, and the RAM location (checked after a full upload missing that index) holds 0.
- **Pipeline stall:** toggle `rd_clk_en` 1-0-0-1-1.
  - `dta_out` changes only on enabled edges, preserving the 2-enable latency.
- **`matrix_count`=2:** `rd_sel`=2 aliases to bank 0.

Source files
------------

// File: rtl/quant_matrix_bank.sv
// MPEG-2 quantiser matrix store: up to four 64-entry matrices with default tracking,
// chroma-follows-luma aliasing and scan-to-raster reordering of uploads.
module quant_matrix_bank #(
  parameter int dta_width    = 8,
  parameter int matrix_count = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           rd_addr,
  input  logic [1:0]           rd_sel,
  input  logic                 rd_clk_en,
  output logic [dta_width-1:0] dta_out,
  input  logic [5:0]           wr_addr,
  input  logic [1:0]           wr_sel,
  input  logic [dta_width-1:0] dta_in,
  input  logic                 wr_clk_en,
  input  logic                 wr_en,
  input  logic                 rst_values,
  input  logic                 alternate_scan,
  output logic                 busy
);
  localparam bit has_chroma = (matrix_count == 32'sd4);
  localparam int bank_width = has_chroma ? 2 : 1;
  localparam int addr_width = 6 + bank_width;

  typedef enum logic [1:0] {INIT = 2'd0, CLEAR = 2'd1, RUN = 2'd2} state_t;

  localparam logic [5:0] zigzag_scan [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63};

  localparam logic [5:0] alt_scan [64] = '{
    6'd0,  6'd8,  6'd16, 6'd24, 6'd1,  6'd9,  6'd2,  6'd10,
    6'd17, 6'd25, 6'd32, 6'd40, 6'd48, 6'd56, 6'd57, 6'd49,
    6'd41, 6'd33, 6'd26, 6'd18, 6'd3,  6'd11, 6'd4,  6'd12,
    6'd19, 6'd27, 6'd34, 6'd42, 6'd50, 6'd58, 6'd35, 6'd43,
    6'd51, 6'd59, 6'd20, 6'd28, 6'd5,  6'd13, 6'd6,  6'd14,
    6'd21, 6'd29, 6'd36, 6'd44, 6'd52, 6'd60, 6'd37, 6'd45,
    6'd53, 6'd61, 6'd22, 6'd30, 6'd7,  6'd15, 6'd23, 6'd31,
    6'd38, 6'd46, 6'd54, 6'd62, 6'd39, 6'd47, 6'd55, 6'd63};

  localparam logic [7:0] intra_default [64] = '{
    8'd8,  8'd16, 8'd19, 8'd22, 8'd26, 8'd27, 8'd29, 8'd34,
    8'd16, 8'd16, 8'd22, 8'd24, 8'd27, 8'd29, 8'd34, 8'd37,
    8'd19, 8'd22, 8'd26, 8'd27, 8'd29, 8'd34, 8'd34, 8'd38,
    8'd22, 8'd22, 8'd26, 8'd27, 8'd29, 8'd34, 8'd37, 8'd40,
    8'd22, 8'd26, 8'd27, 8'd29, 8'd32, 8'd35, 8'd40, 8'd48,
    8'd26, 8'd27, 8'd29, 8'd32, 8'd35, 8'd40, 8'd48, 8'd58,
    8'd26, 8'd27, 8'd29, 8'd34, 8'd38, 8'd46, 8'd56, 8'd69,
    8'd27, 8'd29, 8'd35, 8'd38, 8'd46, 8'd56, 8'd69, 8'd83};

  function automatic logic [5:0] scan_reverse(input logic alt, input logic [5:0] idx);
    if (alt) scan_reverse = alt_scan[idx];
    else     scan_reverse = zigzag_scan[idx];
  endfunction

  state_t                  state_r, state_s;
  logic [addr_width-1:0]   clear_addr_r;
  logic                    wr_pend_r, wr_last_r;
  logic [1:0]              wr_sel_r;
  logic [5:0]              wr_raddr_r;
  logic [dta_width-1:0]    wr_dta_r;
  logic [matrix_count-1:0] default_r;
  logic [1:0]              follow_r;
  logic [dta_width-1:0]    dflt_val_r;
  logic                    dflt_flag_r;

  logic                    ram_we_s;
  logic [addr_width-1:0]   ram_waddr_s;
  logic [dta_width-1:0]    ram_wdta_s;
  logic [dta_width-1:0]    ram_q_s;
  logic [bank_width-1:0]   wr_bank_s, rd_bank_s;
  logic [1:0]              rd_sel_eff_s;
  logic                    rd_flag_s;
  logic [dta_width-1:0]    rd_dflt_s;

  assign wr_bank_s = wr_sel_r[bank_width-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= INIT;
      busy    <= 1'b1;
    end else begin
      state_r <= state_s;
      busy    <= (state_s != RUN);
    end
  end

  // CLEAR owns the RAM write port; afterwards the registered upload write does
  always_comb begin
    state_s     = state_r;
    ram_we_s    = 1'b0;
    ram_waddr_s = {addr_width{1'b0}};
    ram_wdta_s  = {dta_width{1'b0}};
    case (state_r)
      INIT: state_s = CLEAR;
      CLEAR: begin
        ram_we_s    = 1'b1;
        ram_waddr_s = clear_addr_r;
        if (clear_addr_r == {addr_width{1'b1}}) state_s = RUN;
        else                                    state_s = CLEAR;
      end
      RUN: begin
        state_s     = RUN;
        ram_we_s    = wr_pend_r;
        ram_waddr_s = {wr_bank_s, wr_raddr_r};
        ram_wdta_s  = wr_dta_r;
      end
      default: state_s = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst)                  clear_addr_r <= {addr_width{1'b0}};
    else if (state_r == CLEAR) clear_addr_r <= clear_addr_r + {{(addr_width-1){1'b0}}, 1'b1};
    else                       clear_addr_r <= {addr_width{1'b0}};
  end

  // A completing write issued alongside rst_values must not clear the flags it just restored
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_pend_r  <= 1'b0;
      wr_last_r  <= 1'b0;
      wr_sel_r   <= 2'd0;
      wr_raddr_r <= 6'd0;
      wr_dta_r   <= {dta_width{1'b0}};
    end else begin
      wr_pend_r  <= (state_r == RUN) && wr_clk_en && wr_en;
      wr_last_r  <= (state_r == RUN) && wr_clk_en && wr_en && (wr_addr == 6'd63) && !rst_values;
      wr_sel_r   <= wr_sel;
      wr_raddr_r <= scan_reverse(alternate_scan, wr_addr);
      wr_dta_r   <= dta_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      default_r <= {matrix_count{1'b1}};
      follow_r  <= 2'b11;
    end else if (wr_clk_en && rst_values) begin
      default_r <= {matrix_count{1'b1}};
      follow_r  <= 2'b11;
    end else if (wr_last_r) begin
      default_r[wr_bank_s] <= 1'b0;
      // a finished luma upload re-attaches its chroma twin, a finished chroma upload detaches it
      if (has_chroma) follow_r[wr_sel_r[0]] <= ~wr_sel_r[1];
    end
  end

  always_comb begin
    rd_sel_eff_s = rd_sel;
    if (has_chroma && rd_sel[1] && follow_r[rd_sel[0]]) rd_sel_eff_s = {1'b0, rd_sel[0]};
    else                                                rd_sel_eff_s = rd_sel;
    rd_bank_s = rd_sel_eff_s[bank_width-1:0];
    rd_flag_s = default_r[rd_bank_s];
    if (rd_sel[0]) rd_dflt_s = dta_width'(8'd16);
    else           rd_dflt_s = dta_width'(intra_default[rd_addr]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dflt_val_r  <= {dta_width{1'b0}};
      dflt_flag_r <= 1'b0;
      dta_out     <= {dta_width{1'b0}};
    end else if (rd_clk_en) begin
      dflt_val_r  <= rd_dflt_s;
      dflt_flag_r <= rd_flag_s;
      dta_out     <= dflt_flag_r ? dflt_val_r : ram_q_s;
    end
  end

  dpram_sc #(.addr_width(addr_width), .dta_width(dta_width)) u_ram (
    .clk     (clk),
    .wr_en   (ram_we_s),
    .wr_addr (ram_waddr_s),
    .wr_dta  (ram_wdta_s),
    .rd_en   (rd_clk_en),
    .rd_addr ({rd_bank_s, rd_addr}),
    .rd_dta  (ram_q_s)
  );
endmodule

// Single-clock dual-port RAM with registered read (read-old on same-address collision).
module dpram_sc #(
  parameter int addr_width = 6,
  parameter int dta_width  = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [addr_width-1:0] wr_addr,
  input  logic [dta_width-1:0]  wr_dta,
  input  logic                  rd_en,
  input  logic [addr_width-1:0] rd_addr,
  output logic [dta_width-1:0]  rd_dta
);
  logic [dta_width-1:0] mem_r [2**addr_width];

  always_ff @(posedge clk) begin
    if (wr_en) mem_r[wr_addr] <= wr_dta;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_dta <= mem_r[rd_addr];
  end
endmodule

// File: tb/tb_quant_matrix_bank.sv
// Scoreboard bench for quant_matrix_bank (4-matrix instance plus a 2-matrix instance).
module tb_quant_matrix_bank;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic [5:0] rd_addr = 6'd0;
  logic [1:0] rd_sel = 2'd0;
  logic       rd_clk_en = 1'b1;
  logic [7:0] dta_out, dta_out2;
  logic [5:0] wr_addr = 6'd0;
  logic [1:0] wr_sel = 2'd0;
  logic [7:0] dta_in = 8'd0;
  logic       wr_clk_en = 1'b0, wr_en = 1'b0, rst_values = 1'b0, alternate_scan = 1'b0;
  logic       busy, busy2;

  quant_matrix_bank #(.dta_width(8), .matrix_count(4)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_sel(rd_sel), .rd_clk_en(rd_clk_en),
    .dta_out(dta_out), .wr_addr(wr_addr), .wr_sel(wr_sel), .dta_in(dta_in),
    .wr_clk_en(wr_clk_en), .wr_en(wr_en), .rst_values(rst_values),
    .alternate_scan(alternate_scan), .busy(busy));

  quant_matrix_bank #(.dta_width(8), .matrix_count(2)) dut2 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_sel(rd_sel), .rd_clk_en(rd_clk_en),
    .dta_out(dta_out2), .wr_addr(wr_addr), .wr_sel(wr_sel), .dta_in(dta_in),
    .wr_clk_en(wr_clk_en), .wr_en(wr_en), .rst_values(rst_values),
    .alternate_scan(alternate_scan), .busy(busy2));

  localparam int intra_tbl [64] = '{
    8, 16, 19, 22, 26, 27, 29, 34,   16, 16, 22, 24, 27, 29, 34, 37,
    19, 22, 26, 27, 29, 34, 34, 38,  22, 22, 26, 27, 29, 34, 37, 40,
    22, 26, 27, 29, 32, 35, 40, 48,  26, 27, 29, 32, 35, 40, 48, 58,
    26, 27, 29, 34, 38, 46, 56, 69,  27, 29, 35, 38, 46, 56, 69, 83};

  typedef struct {int e; int e2; int s; int a;} exp_t;
  exp_t exp_q[$];
  int   n_chk = 0, n_fail = 0;
  int   last_exp = 0;
  logic chk_issue = 1'b0, hold_chk = 1'b0;
  logic s1_trk = 1'b0, out_new = 1'b0, en_q = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] s, input logic [5:0] a, input int e, input int e2 = -1);
    exp_t it;
    it.e = e; it.e2 = e2; it.s = int'(s); it.a = int'(a);
    rd_sel = s; rd_addr = a; rd_clk_en = 1'b1; chk_issue = 1'b1;
    exp_q.push_back(it);
    tick();
    chk_issue = 1'b0;
  endtask

  task automatic idle(input int n);
    wr_en = 1'b0; rd_clk_en = 1'b1; chk_issue = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic upload(input logic [1:0] sel, input logic alt, input int first, input int last,
                        input int base, input int step, input int skip);
    for (int i = first; i <= last; i++) begin
      wr_clk_en = 1'b1; wr_sel = sel; alternate_scan = alt;
      wr_addr = 6'(i); dta_in = 8'(base + step * i); wr_en = (i != skip);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic pulse_rst_values();
    wr_clk_en = 1'b1; rst_values = 1'b1;
    tick();
    rst_values = 1'b0;
  endtask

  task automatic wait_busy_low(output int cnt);
    cnt = 0;
    @(negedge clk);
    while (busy === 1'b1 && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  // Tag which output loads come from tracked reads, mirroring the two enable-gated stages
  always @(posedge clk) begin
    en_q    <= rd_clk_en;
    out_new <= rd_clk_en && s1_trk;
    if (rd_clk_en) s1_trk <= chk_issue;
  end

  initial begin
    exp_t it;
    forever begin
      @(negedge clk);
      if (out_new) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          it = exp_q.pop_front();
          chk($sformatf("rd sel=%0d addr=%0d", it.s, it.a), dta_out, it.e);
          if (it.e2 >= 0) chk($sformatf("rd_mc2 sel=%0d addr=%0d", it.s, it.a), dta_out2, it.e2);
          last_exp = it.e;
        end
      end else if (hold_chk && !en_q) begin
        chk("stall_hold", dta_out, last_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    // reset and clear
    tick(); tick(); tick();
    chk("rst_dta_out", dta_out, 0);
    chk("rst_busy", busy, 1);
    chk("rst_dta_out_mc2", dta_out2, 0);
    rst = 1'b1;
    wait_busy_low(cnt);
    chk("busy_cycles", cnt, 257);
    chk("busy_mc2_done", busy2, 0);

    for (int a = 0; a < 64; a++) rd(2'd0, 6'(a), intra_tbl[a]);
    for (int a = 0; a < 64; a += 9) rd(2'd1, 6'(a), 16);
    rd(2'd3, 6'd5, 16);
    rd(2'd2, 6'd63, 83);

    // zigzag intra upload, value = scan index + 1; first read lands one cycle too early
    upload(2'd0, 1'b0, 0, 63, 1, 1, -1);
    rd(2'd0, 6'd63, 83);
    rd(2'd0, 6'd63, 64);
    rd(2'd0, 6'd0, 1);  rd(2'd0, 6'd1, 2);  rd(2'd0, 6'd8, 3);
    rd(2'd0, 6'd16, 4); rd(2'd0, 6'd9, 5);  rd(2'd0, 6'd7, 29);
    rd(2'd2, 6'd1, 2);  rd(2'd2, 6'd8, 3);  rd(2'd2, 6'd7, 29);

    // chroma override, then revert everything
    upload(2'd2, 1'b0, 0, 63, 50, 0, -1);
    idle(1);
    rd(2'd2, 6'd0, 50); rd(2'd2, 6'd63, 50); rd(2'd0, 6'd1, 2); rd(2'd3, 6'd4, 16);
    pulse_rst_values();
    rd(2'd0, 6'd2, 19); rd(2'd2, 6'd2, 19); rd(2'd1, 6'd2, 16); rd(2'd3, 6'd2, 16);

    // alternate scan, partial then completing upload
    upload(2'd1, 1'b1, 0, 62, 100, 1, -1);
    idle(1);
    rd(2'd1, 6'd0, 16); rd(2'd1, 6'd10, 16); rd(2'd3, 6'd0, 16);
    upload(2'd1, 1'b1, 63, 63, 7, 0, -1);
    idle(1);
    rd(2'd1, 6'd63, 7); rd(2'd1, 6'd0, 100); rd(2'd1, 6'd8, 101);
    rd(2'd1, 6'd1, 104); rd(2'd3, 6'd8, 101);

    // rst_values together with the completing write
    wr_clk_en = 1'b1; rst_values = 1'b1; wr_en = 1'b1; wr_sel = 2'd1;
    wr_addr = 6'd63; dta_in = 8'd9; alternate_scan = 1'b1;
    tick();
    rst_values = 1'b0; wr_en = 1'b0;
    idle(1);
    rd(2'd1, 6'd63, 16); rd(2'd3, 6'd63, 16);

    // reset mid-operation, write during busy is dropped
    idle(4);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    idle(2);
    wr_clk_en = 1'b1; wr_en = 1'b1; wr_sel = 2'd0; wr_addr = 6'd5; dta_in = 8'd99; alternate_scan = 1'b0;
    tick();
    wr_en = 1'b0;
    wait_busy_low(cnt);
    chk("busy_cleared_after_rerst", busy, 0);
    rd(2'd0, 6'd2, 19);
    upload(2'd0, 1'b0, 0, 63, 1, 1, 5);
    idle(1);
    rd(2'd0, 6'd2, 0); rd(2'd0, 6'd1, 2);

    // read pipeline stall with enable pattern 1-0-0-1-1
    rd(2'd0, 6'd1, 2); rd(2'd0, 6'd8, 3);
    rd_clk_en = 1'b0; hold_chk = 1'b1;
    tick(); tick();
    rd(2'd0, 6'd0, 1);
    hold_chk = 1'b0;
    rd(2'd0, 6'd9, 5);

    // two-matrix instance: chroma selects alias onto the luma banks
    pulse_rst_values();
    upload(2'd2, 1'b0, 0, 63, 40, 0, -1);
    idle(1);
    rd(2'd0, 6'd0, 8, 40);
    rd(2'd2, 6'd0, 40, 40);
    rd(2'd3, 6'd0, 16, 16);
    rd(2'd1, 6'd0, 16, 16);

    idle(4);
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 10) begin
      tick();
      cnt++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
